vproc_mem_resp: RTL and testbench
=================================

VPROC_MEM_RESP -- requirements
Module: vproc_mem_resp

Interface
REQ-001 SHALL have parameter MEM_W, default 32, the memory data bus width in bits (multiple of 32).
REQ-002 SHALL have parameter MEM_BYTES, default 4096, the backing store size in bytes (power of two, at least MEM_W/8).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000, the first byte address served (MEM_BYTES-aligned).
REQ-004 SHALL have parameter LATENCY, default 1, the request-to-response delay in cycles (range 1..4).
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port mem_req_i, input, 1 bit: request valid; always accepted, no grant.
REQ-008 SHALL have port mem_addr_i, input, 32 bits: byte address.
REQ-009 SHALL have port mem_we_i, input, 1 bit: 1 = write, 0 = read.
REQ-010 SHALL have port mem_be_i, input, MEM_W/8 bits: write byte enables.
REQ-011 SHALL have port mem_wdata_i, input, MEM_W bits: write data.
REQ-012 SHALL have port mem_rvalid_o, output, 1 bit: response valid.
REQ-013 SHALL have port mem_err_o, output, 1 bit: response error, qualified by mem_rvalid_o.
REQ-014 SHALL have port mem_rdata_o, output, MEM_W bits: read data, qualified by mem_rvalid_o.

Function
REQ-015 SHALL accept a request on every cycle mem_req_i=1; back-to-back requests at full rate.
REQ-016 SHALL assert mem_rvalid_o for exactly one cycle, exactly LATENCY cycles after each accepted request; responses in request order.
REQ-017 SHALL flag a request as erroneous if the address is outside [BASE_ADDR, BASE_ADDR+MEM_BYTES-1] or the low log2(MEM_W/8) address bits are nonzero.
REQ-018 SHALL, for an erroneous request, respond with mem_err_o=1 and mem_rdata_o=0, and leave the store unmodified.
REQ-019 SHALL, for a valid write, update only the bytes with mem_be_i=1 at the end of the accept cycle; the response carries mem_err_o=0, mem_rdata_o=0.
REQ-020 SHALL, for a valid read, return the word as of the accept cycle; a write accepted in cycle N is visible to a read accepted in cycle N+1 (no hazard).
REQ-021 SHALL accept a write with mem_be_i all zero as a valid no-op write that still produces a response.
REQ-022 SHALL hold mem_err_o and mem_rdata_o at 0 whenever mem_rvalid_o=0.
REQ-023 SHALL index the store with (mem_addr_i - BASE_ADDR) >> log2(MEM_W/8), truncated to log2(MEM_BYTES*8/MEM_W) bits.

Reset
REQ-024 SHALL, while rst_ni=0 at a clock edge, clear mem_rvalid_o, mem_err_o and mem_rdata_o to 0, and drop every in-flight response.
REQ-025 SHALL produce no response for a request accepted before or during reset, even if reset lasts fewer than LATENCY cycles.
REQ-026 SHALL not clear store contents on reset, and SHALL ignore requests presented while rst_ni=0.

Configuration
REQ-027 SHALL, with macro VPROC_MEM_RESP_ERR_CNT_EN defined, add output err_cnt_o (16 bits): the count of error responses, reset to 0, saturating at 16'hFFFF.
REQ-028 SHALL, without VPROC_MEM_RESP_ERR_CNT_EN, have no err_cnt_o port and no counter logic; all other behaviour identical.

Structure
REQ-029 SHALL place the response record typedef (valid, err, rdata), the LATENCY bounds constants and the address-check function in shared package vproc_mem_pkg.
REQ-030 SHALL implement the byte-enabled storage array as sub-module vproc_mem_sram (one read/write port, synchronous write); the LATENCY delay line SHALL stay in vproc_mem_resp.

Verification
REQ-031 SHALL cover: LATENCY=1, write 0xDEADBEEF to 0x10 with be=4'hF, then read 0x10 -> rvalid one cycle after each request; read returns 0xDEADBEEF, err=0.
REQ-032 SHALL cover: with 0x10 = 0xDEADBEEF, write 0x00000011 with be=4'b0001, then read -> read returns 0xDEADBE11.
REQ-033 SHALL cover: read of 0x1000 (MEM_BYTES=4096) and read of 0x2 -> each responds err=1, rdata=0; store unchanged.
REQ-034 SHALL cover: LATENCY=3, four back-to-back reads -> four consecutive rvalid pulses starting 3 cycles after the first request, in order.
REQ-035 SHALL cover: LATENCY=3, two reads issued, rst_ni low for 1 cycle at the next edge -> no rvalid; store intact on subsequent read.
REQ-036 SHALL cover: with VPROC_MEM_RESP_ERR_CNT_EN, 3 out-of-range requests -> err_cnt_o=3; reset -> err_cnt_o=0.

Source files
------------

// File: rtl/vproc_mem_pkg.sv
// Shared response record, latency bounds and address check for the
// vproc memory responder.
package vproc_mem_pkg;

  localparam int unsigned LAT_MIN = 1;
  localparam int unsigned LAT_MAX = 4;

  // Widest data bus a response record can carry.
  localparam int unsigned RDATA_MAX_W = 1024;

  typedef struct packed {
    logic                   valid;
    logic                   err;
    logic [RDATA_MAX_W-1:0] rdata;
  } mem_resp_t;

  // An address below base wraps to a huge offset, so one compare
  // covers both ends of the window.
  function automatic logic addr_err(
    input logic [31:0] addr,
    input logic [31:0] base,
    input logic [32:0] bytes,
    input logic [31:0] align_mask
  );
    logic [32:0] off;
    off = {1'b0, addr} - {1'b0, base};
    return (off >= bytes) || ((addr & align_mask) != '0);
  endfunction

endpackage

// File: rtl/vproc_mem_sram.sv
// Byte-enabled single-port store: combinational read,
// write on the rising clock edge.
module vproc_mem_sram
  import vproc_mem_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned WORDS = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW/8-1:0] be_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < int'(DW / 8); b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/vproc_mem_resp.sv
// Fixed-latency memory responder; define VPROC_MEM_RESP_ERR_CNT_EN
// to add a saturating error-response counter on err_cnt_o.
module vproc_mem_resp
  import vproc_mem_pkg::*;
#(
  parameter int unsigned MEM_W     = 32,
  parameter int unsigned MEM_BYTES = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned LATENCY   = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               mem_req_i,
  input  logic [31:0]        mem_addr_i,
  input  logic               mem_we_i,
  input  logic [MEM_W/8-1:0] mem_be_i,
  input  logic [MEM_W-1:0]   mem_wdata_i,
  output logic               mem_rvalid_o,
  output logic               mem_err_o,
  output logic [MEM_W-1:0]   mem_rdata_o
`ifdef VPROC_MEM_RESP_ERR_CNT_EN
  ,
  output logic [15:0]        err_cnt_o
`endif
);

  localparam int unsigned BB    = MEM_W / 8;
  localparam int unsigned OFF_W = $clog2(BB);
  localparam int unsigned WORDS = MEM_BYTES / BB;
  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned LAT   =
    (LATENCY < LAT_MIN) ? LAT_MIN :
    (LATENCY > LAT_MAX) ? LAT_MAX : LATENCY;

  logic             acc;
  logic             bad;
  logic             wr;
  logic [31:0]      off;
  logic [IDX_W-1:0] idx;
  logic [MEM_W-1:0] sram_rdata;

  mem_resp_t [LAT-1:0] pipe_d;
  mem_resp_t [LAT-1:0] pipe_q;

  always_comb begin
    acc = mem_req_i & rst_ni;
    bad = addr_err(mem_addr_i, BASE_ADDR,
                   33'(MEM_BYTES), 32'(BB - 1));
    wr  = acc & mem_we_i & ~bad;
    off = mem_addr_i - BASE_ADDR;
    idx = off[OFF_W +: IDX_W];
  end

  vproc_mem_sram #(
    .DW    (MEM_W),
    .WORDS (WORDS),
    .AW    (IDX_W)
  ) u_sram (
    .clk_i   (clk_i),
    .we_i    (wr),
    .addr_i  (idx),
    .be_i    (mem_be_i),
    .wdata_i (mem_wdata_i),
    .rdata_o (sram_rdata)
  );

  // Read data is captured in the accept cycle, so a later write
  // cannot disturb a response already in flight.
  always_comb begin
    pipe_d          = '0;
    pipe_d[0].valid = acc;
    pipe_d[0].err   = acc & bad;
    if (acc && !bad && !mem_we_i) begin
      pipe_d[0].rdata = RDATA_MAX_W'(sram_rdata);
    end
    for (int i = 1; i < int'(LAT); i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign mem_rvalid_o = pipe_q[LAT-1].valid;
  assign mem_err_o    = pipe_q[LAT-1].err;
  assign mem_rdata_o  = pipe_q[LAT-1].rdata[MEM_W-1:0];

  logic unused_bits;
  assign unused_bits = ^{off, pipe_q[LAT-1].rdata};

`ifdef VPROC_MEM_RESP_ERR_CNT_EN
  logic [15:0] err_cnt_d;
  logic [15:0] err_cnt_q;

  // Counts the response entering the output stage, so the count
  // already includes an error currently on mem_err_o.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (pipe_d[LAT-1].valid && pipe_d[LAT-1].err &&
        err_cnt_q != 16'hFFFF) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_vproc_mem_resp.sv
// Bench for vproc_mem_resp: LATENCY=1 and LATENCY=3 instances share
// stimulus; each is checked against a byte-level memory model.
module tb_vproc_mem_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;

  logic        rv1, er1, rv3, er3;
  logic [31:0] rd1, rd3;
`ifdef VPROC_MEM_RESP_ERR_CNT_EN
  logic [15:0] ec1, ec3;
`endif

  always #5 clk = ~clk;

  vproc_mem_resp #(
    .MEM_W(32), .MEM_BYTES(4096),
    .BASE_ADDR(32'h0), .LATENCY(1)
  ) u_l1 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .mem_req_i   (req),
    .mem_addr_i  (addr),
    .mem_we_i    (we),
    .mem_be_i    (be),
    .mem_wdata_i (wdata),
    .mem_rvalid_o(rv1),
    .mem_err_o   (er1),
    .mem_rdata_o (rd1)
`ifdef VPROC_MEM_RESP_ERR_CNT_EN
    ,
    .err_cnt_o   (ec1)
`endif
  );

  vproc_mem_resp #(
    .MEM_W(32), .MEM_BYTES(4096),
    .BASE_ADDR(32'h0), .LATENCY(3)
  ) u_l3 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .mem_req_i   (req),
    .mem_addr_i  (addr),
    .mem_we_i    (we),
    .mem_be_i    (be),
    .mem_wdata_i (wdata),
    .mem_rvalid_o(rv3),
    .mem_err_o   (er3),
    .mem_rdata_o (rd3)
`ifdef VPROC_MEM_RESP_ERR_CNT_EN
    ,
    .err_cnt_o   (ec3)
`endif
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    logic        rst_n;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        chk;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  exp_t       sched1[int];
  exp_t       sched3[int];
  logic [7:0] mem_m [4096];
  int         edge_n = 0;
  int         n_vec = 0;
  int         n_mis = 0;
  int         cnt1 = 0;
  int         cnt3 = 0;
  vec_t       tbl[$];

  function automatic vec_t mk(
    input logic r, input logic q, input logic w,
    input logic [31:0] a, input logic [3:0] b,
    input logic [31:0] d, input logic c,
    input logic e, input logic [31:0] x
  );
    vec_t v;
    v.rst_n = r; v.req = q; v.we = w;
    v.addr = a; v.be = b; v.wdata = d;
    v.chk = c; v.err = e; v.rdata = x;
    return v;
  endfunction

  function automatic logic model_err(input logic [31:0] a);
    return (a >= 32'd4096) || (a[1:0] != 2'b00);
  endfunction

  task automatic cmp(
    input string nm, input logic rv, input logic er,
    input logic [31:0] rd, input logic h, input exp_t x
  );
    logic [33:0] act;
    logic [33:0] want;
    act  = {rv, er, rd};
    want = h ? {1'b1, x.err, x.rdata} : 34'd0;
    n_vec++;
    if (act !== want) begin
      n_mis++;
      $display("FAIL %s edge %0d: got rv=%0b err=%0b rdata=%08h, want rv=%0b err=%0b rdata=%08h",
               nm, edge_n, rv, er, rd, want[33], want[32], want[31:0]);
    end
  endtask

  task automatic step(input vec_t v);
    exp_t e, x1, x3;
    logic h1, h3;
    rst_n = v.rst_n; req = v.req; we = v.we;
    addr = v.addr; be = v.be; wdata = v.wdata;
    @(posedge clk);
    edge_n++;
    if (!v.rst_n) begin
      sched1.delete();
      sched3.delete();
      cnt1 = 0;
      cnt3 = 0;
    end else if (v.req) begin
      e.err   = model_err(v.addr);
      e.rdata = '0;
      if (!e.err && !v.we) begin
        for (int b = 0; b < 4; b++) begin
          e.rdata[b*8 +: 8] = mem_m[v.addr + 32'(b)];
        end
      end
      if (v.chk) begin
        e.err   = v.err;
        e.rdata = v.rdata;
      end
      sched1[edge_n]     = e;
      sched3[edge_n + 2] = e;
      if (v.we && !model_err(v.addr)) begin
        for (int b = 0; b < 4; b++) begin
          if (v.be[b]) mem_m[v.addr + 32'(b)] = v.wdata[b*8 +: 8];
        end
      end
    end
    #1;
    h1 = sched1.exists(edge_n);
    x1.err = 1'b0; x1.rdata = '0;
    if (h1) begin x1 = sched1[edge_n]; sched1.delete(edge_n); end
    h3 = sched3.exists(edge_n);
    x3.err = 1'b0; x3.rdata = '0;
    if (h3) begin x3 = sched3[edge_n]; sched3.delete(edge_n); end
    cmp("lat1_resp", rv1, er1, rd1, h1, x1);
    cmp("lat3_resp", rv3, er3, rd3, h3, x3);
    if (h1 && x1.err && cnt1 < 65535) cnt1++;
    if (h3 && x3.err && cnt3 < 65535) cnt3++;
`ifdef VPROC_MEM_RESP_ERR_CNT_EN
    n_vec++;
    if (ec1 !== 16'(cnt1)) begin
      n_mis++;
      $display("FAIL lat1_err_cnt edge %0d: got %0d want %0d", edge_n, ec1, cnt1);
    end
    n_vec++;
    if (ec3 !== 16'(cnt3)) begin
      n_mis++;
      $display("FAIL lat3_err_cnt edge %0d: got %0d want %0d", edge_n, ec3, cnt3);
    end
`endif
  endtask

  localparam logic [31:0] Z = 32'h0;

  initial begin
    vec_t v;
    logic [31:0] a;
    int kind;

    // reset state
    for (int i = 0; i < 3; i++) step(mk(0, 0, 0, Z, 4'h0, Z, 0, 0, Z));

    // fill the store so every read has a known value
    for (int i = 0; i < 1024; i++) begin
      step(mk(1, 1, 1, 32'(i * 4), 4'hF, $urandom, 0, 0, Z));
    end

    tbl.push_back(mk(1, 1, 1, 32'h10,  4'hF, 32'hDEADBEEF, 1, 0, Z));
    tbl.push_back(mk(1, 1, 0, 32'h10,  4'h0, Z,            1, 0, 32'hDEADBEEF));
    tbl.push_back(mk(1, 1, 1, 32'h10,  4'h1, 32'h00000011, 1, 0, Z));
    tbl.push_back(mk(1, 1, 0, 32'h10,  4'h0, Z,            1, 0, 32'hDEADBE11));
    tbl.push_back(mk(1, 1, 0, 32'h1000, 4'h0, Z,           1, 1, Z));
    tbl.push_back(mk(1, 1, 0, 32'h2,   4'h0, Z,            1, 1, Z));
    tbl.push_back(mk(1, 1, 1, 32'h1000, 4'hF, 32'h5,       1, 1, Z));
    tbl.push_back(mk(1, 1, 1, 32'h10,  4'h0, 32'hFFFFFFFF, 1, 0, Z));
    tbl.push_back(mk(1, 1, 1, 32'h13,  4'hF, 32'h0,        1, 1, Z));
    tbl.push_back(mk(1, 1, 0, 32'h10,  4'h0, Z,            1, 0, 32'hDEADBE11));
    tbl.push_back(mk(1, 0, 0, Z,       4'h0, Z,            0, 0, Z));
    tbl.push_back(mk(1, 1, 1, 32'hFFC, 4'hF, 32'h12345678, 1, 0, Z));
    tbl.push_back(mk(1, 1, 0, 32'hFFC, 4'h0, Z,            1, 0, 32'h12345678));
    tbl.push_back(mk(1, 1, 1, 32'hFFC, 4'hC, 32'hAABBCCDD, 1, 0, Z));
    tbl.push_back(mk(1, 1, 0, 32'hFFC, 4'h0, Z,            1, 0, 32'hAABB5678));
    tbl.push_back(mk(1, 1, 0, 32'hFFE, 4'h0, Z,            1, 1, Z));
    tbl.push_back(mk(1, 1, 0, 32'hFFFFFFFC, 4'h0, Z,       1, 1, Z));
    foreach (tbl[i]) step(tbl[i]);
    for (int i = 0; i < 4; i++) step(mk(1, 0, 0, Z, 4'h0, Z, 0, 0, Z));

    // two reads then a one-cycle reset: LAT3 responses are dropped
    step(mk(1, 1, 0, 32'h10,  4'h0, Z, 1, 0, 32'hDEADBE11));
    step(mk(1, 1, 0, 32'hFFC, 4'h0, Z, 1, 0, 32'hAABB5678));
    step(mk(0, 0, 0, Z, 4'h0, Z, 0, 0, Z));
    for (int i = 0; i < 4; i++) step(mk(1, 0, 0, Z, 4'h0, Z, 0, 0, Z));
    step(mk(1, 1, 0, 32'h10, 4'h0, Z, 1, 0, 32'hDEADBE11));

    // a write presented during reset must be ignored
    step(mk(0, 1, 1, 32'h10, 4'hF, 32'h0, 0, 0, Z));
    step(mk(1, 0, 0, Z, 4'h0, Z, 0, 0, Z));
    step(mk(1, 1, 0, 32'h10, 4'h0, Z, 1, 0, 32'hDEADBE11));

    // three errors after reset
    step(mk(0, 0, 0, Z, 4'h0, Z, 0, 0, Z));
    for (int i = 0; i < 3; i++) step(mk(1, 1, 0, 32'h2000, 4'h0, Z, 1, 1, Z));
    for (int i = 0; i < 4; i++) step(mk(1, 0, 0, Z, 4'h0, Z, 0, 0, Z));

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      kind = int'($urandom_range(0, 9));
      if (kind < 7)       a = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      else if (kind == 7) a = 32'($urandom_range(0, 4095)) | 32'h1;
      else if (kind == 8) a = 32'h1000 + 32'($urandom_range(0, 8191));
      else                a = $urandom;
      v = mk($urandom_range(0, 99) != 0, $urandom_range(0, 9) < 8,
             1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)),
             $urandom, 0, 0, Z);
      step(v);
    end
    for (int i = 0; i < 4; i++) step(mk(1, 0, 0, Z, 4'h0, Z, 0, 0, Z));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
